// File: rtl/mux_scan_pkg.sv
// Shared state encoding and default sizing for the mux scan controller.
package mux_scan_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, PRESENT} scan_state_t;

   localparam int NUM_CH_DEF     = 4;
   localparam int SETTLE_CYC_DEF = 1;

endpackage

// File: rtl/scan_settle_cnt.sv
// Loadable down-counter that times how long sel is held before sampling Y.
module scan_settle_cnt #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller: steps the mux select, samples Y per channel and
// presents the rebuilt word on a valid/ready port.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter  int NUM_CH     = NUM_CH_DEF,
   parameter  int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter  bit CONTINUOUS = 1'b0,
   localparam int SEL_W      = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [SEL_W-1:0]  sel,
   input  logic              mux_y,
   output logic [NUM_CH-1:0] data,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              busy
);

   localparam int                CNT_W       = $clog2(SETTLE_CYC + 1);
   localparam logic [SEL_W-1:0]  LAST_CH     = SEL_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

   scan_state_t       state_reg, state_next;
   logic [SEL_W-1:0]  ch_reg, ch_next;
   logic [NUM_CH-1:0] shadow_reg, shadow_next;
   logic [NUM_CH-1:0] data_reg, data_next;
   logic              cnt_load, cnt_dec, cnt_zero;

   // The counter is loaded with SETTLE_CYC-1 so zero is seen on the last dwell cycle.
   scan_settle_cnt #(
      .W (CNT_W)
   ) u_settle_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (SETTLE_LOAD),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         ch_reg     <= '0;
         shadow_reg <= '0;
         data_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         ch_reg     <= ch_next;
         shadow_reg <= shadow_next;
         data_reg   <= data_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      ch_next     = ch_reg;
      shadow_next = shadow_reg;
      data_next   = data_reg;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start || CONTINUOUS) begin
               state_next = SETTLE;
               ch_next    = '0;
               cnt_load   = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_zero) begin
               state_next = SAMPLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         SAMPLE: begin
            shadow_next[ch_reg] = mux_y;
            if (ch_reg == LAST_CH) begin
               // The final bit is merged here so data changes only on this edge.
               data_next  = shadow_next;
               state_next = PRESENT;
            end else begin
               ch_next    = ch_reg + 1'b1;
               cnt_load   = 1'b1;
               state_next = SETTLE;
            end
         end
         PRESENT: begin
            if (data_ready) begin
               if (start || CONTINUOUS) begin
                  state_next = SETTLE;
                  ch_next    = '0;
                  cnt_load   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign sel        = ((state_reg == SETTLE) || (state_reg == SAMPLE)) ? ch_reg : '0;
   assign data       = data_reg;
   assign data_valid = (state_reg == PRESENT);
   assign busy       = (state_reg != IDLE);

endmodule
